// File: rtl/acc_window_delta.sv
// Per-window accumulator delta: snapshot the total every WINDOW enables and emit the difference from the previous snapshot.
// The result appears 2 cycles after the completing enable; while the 2-entry buffer is full, new results are dropped and o_OVERFLOW latches.
module acc_window_delta #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET,
  input  logic                  i_ENABLE,
  input  logic [DATA_WIDTH-1:0] i_ACC_TOTAL,
  output logic                  o_VALID,
  input  logic                  i_READY,
  output logic [DATA_WIDTH-1:0] o_DELTA,
  output logic                  o_OVERFLOW,
  output logic [1:0]            o_LEVEL
);

  localparam int CNT_WIDTH = $clog2(WINDOW);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WINDOW - 1);

  if (WINDOW < 2 || WINDOW > 65535) begin : g_bad_window
    $error("acc_window_delta: WINDOW must be in 2..65535");
  end

  typedef enum logic {
    ST_COUNT   = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] baseline;
  logic [DATA_WIDTH-1:0] delta;
  logic [DATA_WIDTH-1:0] tail;
  logic                  push;
  logic                  pop;

  // i_ACC_TOTAL already includes the completing enable while in CAPTURE.
  assign delta = i_ACC_TOTAL - baseline;
  assign push  = (state == ST_CAPTURE);
  assign pop   = o_VALID & i_READY;

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      cnt      <= '0;
      baseline <= '0;
      state    <= ST_COUNT;
    end else begin
      if (i_ENABLE) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_WIDTH'(1);
      end
      case (state)
        ST_COUNT: begin
          if (i_ENABLE && (cnt == CNT_LAST)) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          baseline <= i_ACC_TOTAL;
          state    <= ST_COUNT;
        end
        default: state <= ST_COUNT;
      endcase
    end
  end

  // o_DELTA is the head register and tail is the second slot; all outputs are flops.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      o_DELTA    <= '0;
      tail       <= '0;
      o_LEVEL    <= 2'd0;
      o_VALID    <= 1'b0;
      o_OVERFLOW <= 1'b0;
    end else begin
      case (o_LEVEL)
        2'd0: begin
          if (push) begin
            o_DELTA <= delta;
            o_LEVEL <= 2'd1;
            o_VALID <= 1'b1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            o_DELTA <= delta;
          end else if (push) begin
            tail    <= delta;
            o_LEVEL <= 2'd2;
          end else if (pop) begin
            o_LEVEL <= 2'd0;
            o_VALID <= 1'b0;
          end
        end
        default: begin
          if (pop) begin
            o_DELTA <= tail;
            if (push) begin
              tail <= delta;
            end else begin
              o_LEVEL <= 2'd1;
            end
          end else if (push) begin
            o_OVERFLOW <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_window_delta.sv
// Directed bench for acc_window_delta with WINDOW=4; models the upstream accumulator locally.
module tb_acc_window_delta;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] inc;
  logic [31:0] acc;
  logic        valid;
  logic        rdy;
  logic [31:0] delta;
  logic        ovf;
  logic [1:0]  level;

  int checks = 0;
  int errors = 0;

  acc_window_delta #(.DATA_WIDTH(32), .WINDOW(4)) dut (
    .i_CLK      (clk),
    .i_RESET    (rst),
    .i_ENABLE   (en),
    .i_ACC_TOTAL(acc),
    .o_VALID    (valid),
    .i_READY    (rdy),
    .o_DELTA    (delta),
    .o_OVERFLOW (ovf),
    .o_LEVEL    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered upstream accumulator, reset alongside the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (en) acc <= acc + inc;
  end

  typedef struct {
    logic        en;
    logic [31:0] inc;
    logic        rdy;
    logic        vld;
    logic [1:0]  lvl;
    logic        ovf;
    logic [31:0] dlt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int e, input logic [31:0] i, input int r,
                              input int v, input int l, input int o, input logic [31:0] d);
    vec_t x;
    x.en  = (e != 0);
    x.inc = i;
    x.rdy = (r != 0);
    x.vld = (v != 0);
    x.lvl = 2'(l);
    x.ovf = (o != 0);
    x.dlt = d;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic evld, input logic [1:0] elvl,
                           input logic eovf, input logic [31:0] edlt);
    check({tag, ".valid"}, 32'(valid), 32'(evld));
    check({tag, ".level"}, 32'(level), 32'(elvl));
    check({tag, ".overflow"}, 32'(ovf), 32'(eovf));
    if (evld) check({tag, ".delta"}, delta, edlt);
  endtask

  task automatic step(input logic e, input logic [31:0] i, input logic r);
    @(negedge clk);
    en  = e;
    inc = i;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    en  = 1'b0;
    inc = '0;
    rdy = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_out("reset", 1'b0, 2'd0, 1'b0, 32'd0);
    check("reset.delta", delta, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Windows of 40 and 60, then a wrapping window and one measured across the wrap.
    repeat (4) tbl.push_back(mk(1, 32'd10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'd0, 0, 1, 1, 0, 32'd40));
    repeat (4) tbl.push_back(mk(1, 32'd15, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'd0, 0, 1, 1, 0, 32'd60));
    tbl.push_back(mk(0, 32'd0, 1, 0, 0, 0, 0));
    repeat (4) tbl.push_back(mk(1, 32'h3FFF_FFE3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'd0, 0, 1, 1, 0, 32'hFFFF_FF8C));
    tbl.push_back(mk(0, 32'd0, 1, 0, 0, 0, 0));
    repeat (4) tbl.push_back(mk(1, 32'd8, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'd0, 0, 1, 1, 0, 32'h20));
    tbl.push_back(mk(0, 32'd0, 1, 0, 0, 0, 0));
    // Back-to-back windows of 5, 6 and 7 with the consumer stalled; 7 is dropped.
    tbl.push_back(mk(1, 32'd2, 0, 0, 0, 0, 0));
    repeat (3) tbl.push_back(mk(1, 32'd1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'd3, 0, 1, 1, 0, 32'd5));
    repeat (3) tbl.push_back(mk(1, 32'd1, 0, 1, 1, 0, 32'd5));
    tbl.push_back(mk(1, 32'd4, 0, 1, 2, 0, 32'd5));
    repeat (3) tbl.push_back(mk(1, 32'd1, 0, 1, 2, 0, 32'd5));
    tbl.push_back(mk(0, 32'd0, 0, 1, 2, 1, 32'd5));
    tbl.push_back(mk(0, 32'd0, 1, 1, 1, 1, 32'd6));
    tbl.push_back(mk(0, 32'd0, 1, 0, 0, 1, 32'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].inc, tbl[i].rdy);
      check_out($sformatf("vec%0d", i), tbl[i].vld, tbl[i].lvl, tbl[i].ovf, tbl[i].dlt);
    end

    // Asynchronous reset mid-window with a result pending.
    repeat (4) step(1'b1, 32'd1, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check_out("pre_rst", 1'b1, 2'd1, 1'b1, 32'd4);
    repeat (2) step(1'b1, 32'd1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'd100, 1'b0);
      check_out($sformatf("post_rst%0d", i), 1'b0, 2'd0, 1'b0, 32'd0);
    end
    step(1'b0, 32'd0, 1'b0);
    check_out("post_rst_win", 1'b1, 2'd1, 1'b0, 32'd400);
    step(1'b0, 32'd0, 1'b1);
    check_out("post_rst_pop", 1'b0, 2'd0, 1'b0, 32'd0);

    // Full buffer: push and pop in the same cycle keeps level 2 without overflow.
    step(1'b1, 32'd11, 1'b0);
    repeat (3) step(1'b1, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check_out("fill1", 1'b1, 2'd1, 1'b0, 32'd11);
    step(1'b1, 32'd12, 1'b0);
    repeat (3) step(1'b1, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check_out("fill2", 1'b1, 2'd2, 1'b0, 32'd11);
    step(1'b1, 32'd13, 1'b0);
    repeat (3) step(1'b1, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    check_out("push_pop", 1'b1, 2'd2, 1'b0, 32'd12);
    step(1'b0, 32'd0, 1'b1);
    check_out("drain1", 1'b1, 2'd1, 1'b0, 32'd13);
    step(1'b0, 32'd0, 1'b1);
    check_out("drain2", 1'b0, 2'd0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
